// File: rtl/result_uart_packetizer.sv
// Pairs the sphere-surface and plane-surface results and ships each pair to the host
// as an 11-byte 8N1 UART frame: A5 5A surf[31:0] plane[31:0] xor-checksum.
module result_uart_packetizer #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] surf_data,
    input  logic        surf_valid,
    input  logic [31:0] plane_data,
    input  logic        plane_valid,
    output logic        uart_tx,
    output logic        busy,
    output logic        frame_sent,
    output logic        overrun
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

    state_t      state, state_next;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [3:0]  byte_idx;
    logic [7:0]  tx_byte;
    logic [7:0]  csum;
    logic [63:0] payload;
    logic [31:0] surf_hold, plane_hold;
    logic        surf_pend, plane_pend;
    logic        bit_done, start_frame, frame_done;
    logic [7:0]  snap_csum;

    assign bit_done    = (baud_cnt == 16'd0);
    assign start_frame = (state == IDLE) && surf_pend && plane_pend;
    assign frame_done  = (state == STOP) && bit_done && (byte_idx == 4'd10);
    assign snap_csum   = surf_hold[31:24] ^ surf_hold[23:16] ^ surf_hold[15:8] ^ surf_hold[7:0]
                       ^ plane_hold[31:24] ^ plane_hold[23:16] ^ plane_hold[15:8] ^ plane_hold[7:0];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        uart_tx    = 1'b1;
        busy       = (state != IDLE);
        case (state)
            IDLE:  if (start_frame) state_next = START;
            START: begin
                uart_tx = 1'b0;
                if (bit_done) state_next = DATA;
            end
            DATA: begin
                uart_tx = tx_byte[0];
                if (bit_done && bit_idx == 3'd7) state_next = STOP;
            end
            STOP:  if (bit_done) state_next = (byte_idx == 4'd10) ? IDLE : START;
            default: state_next = IDLE;
        endcase
    end

    // Capture side runs in every state; a set in the frame-start cycle wins over the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            surf_hold  <= '0;
            plane_hold <= '0;
            surf_pend  <= 1'b0;
            plane_pend <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (surf_valid)  surf_hold  <= surf_data;
            if (plane_valid) plane_hold <= plane_data;
            surf_pend  <= surf_valid  | (surf_pend  & ~start_frame);
            plane_pend <= plane_valid | (plane_pend & ~start_frame);
            if (((surf_valid && surf_pend) || (plane_valid && plane_pend)) && !start_frame)
                overrun <= 1'b1;
        end
    end

    // Transmit datapath works only from the snapshot, so live captures never disturb a frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            baud_cnt   <= '0;
            bit_idx    <= '0;
            byte_idx   <= '0;
            tx_byte    <= '0;
            csum       <= '0;
            payload    <= '0;
            frame_sent <= 1'b0;
        end else begin
            frame_sent <= frame_done;
            if (start_frame) begin
                baud_cnt <= BIT_LAST;
                bit_idx  <= '0;
                byte_idx <= '0;
                tx_byte  <= 8'hA5;
                payload  <= {surf_hold, plane_hold};
                csum     <= snap_csum;
            end else if (state != IDLE) begin
                if (!bit_done) begin
                    baud_cnt <= baud_cnt - 16'd1;
                end else begin
                    baud_cnt <= BIT_LAST;
                    if (state == DATA) begin
                        tx_byte <= tx_byte >> 1;
                        bit_idx <= bit_idx + 3'd1;
                    end
                    if (state == STOP && byte_idx != 4'd10) begin
                        byte_idx <= byte_idx + 4'd1;
                        case (byte_idx)
                            4'd0:    tx_byte <= 8'h5A;
                            4'd9:    tx_byte <= csum;
                            default: begin
                                tx_byte <= payload[63:56];
                                payload <= {payload[55:0], 8'h00};
                            end
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_result_uart_packetizer.sv
// Bench for result_uart_packetizer: frame-level model checked every cycle, plus a UART
// receiver whose decoded bytes are compared with hand-computed frames.
module tb_result_uart_packetizer;

    localparam int CPB       = 4;
    localparam int FRAME_CYC = 110 * CPB;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] surf_data = '0, plane_data = '0;
    logic        surf_valid = 1'b0, plane_valid = 1'b0;
    logic        uart_tx, busy, frame_sent, overrun;

    result_uart_packetizer #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset(reset),
        .surf_data(surf_data), .surf_valid(surf_valid),
        .plane_data(plane_data), .plane_valid(plane_valid),
        .uart_tx(uart_tx), .busy(busy), .frame_sent(frame_sent), .overrun(overrun)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Whole frame as a 110-bit serial waveform, bit 0 first on the wire.
    function automatic logic [109:0] frame_bits(input logic [31:0] s, input logic [31:0] p);
        logic [7:0]   b [11];
        logic [109:0] f;
        logic [63:0]  pl;
        pl = {s, p};
        b[0] = 8'hA5;
        b[1] = 8'h5A;
        b[10] = 8'h00;
        for (int i = 0; i < 8; i++) begin
            b[2 + i] = pl[63 - 8 * i -: 8];
            b[10]    = b[10] ^ b[2 + i];
        end
        for (int k = 0; k < 11; k++) begin
            f[k * 10] = 1'b0;
            for (int j = 0; j < 8; j++) f[k * 10 + 1 + j] = b[k][j];
            f[k * 10 + 9] = 1'b1;
        end
        return f;
    endfunction

    // Behavioural model: pending pair, sticky overrun, and a running position inside the frame.
    logic         m_sp = 0, m_pp = 0, m_active = 0, m_ovr = 0, m_fs = 0;
    logic [31:0]  m_sh = '0, m_ph = '0;
    logic [109:0] m_bits = '0;
    int           m_tpos = 0;
    logic         cmp_en = 1'b0;

    initial forever begin
        @(posedge clk);
        if (reset) begin
            m_sp = 0; m_pp = 0; m_active = 0; m_ovr = 0; m_fs = 0;
            m_sh = '0; m_ph = '0; m_tpos = 0;
        end else begin
            logic start;
            start = !m_active && m_sp && m_pp;
            m_fs  = m_active && (m_tpos == FRAME_CYC - 1);
            if (m_active) begin
                m_tpos++;
                if (m_tpos == FRAME_CYC) m_active = 0;
            end else if (start) begin
                m_bits   = frame_bits(m_sh, m_ph);
                m_active = 1;
                m_tpos   = 0;
            end
            if ((surf_valid && m_sp && !start) || (plane_valid && m_pp && !start)) m_ovr = 1;
            if (surf_valid)  m_sh = surf_data;
            if (plane_valid) m_ph = plane_data;
            m_sp = surf_valid  || (m_sp && !start);
            m_pp = plane_valid || (m_pp && !start);
        end
    end

    initial forever begin
        logic exp_tx;
        @(negedge clk);
        if (cmp_en) begin
            exp_tx = m_active ? m_bits[m_tpos / CPB] : 1'b1;
            check("model_tx",         uart_tx,    exp_tx);
            check("model_busy",       busy,       m_active);
            check("model_frame_sent", frame_sent, m_fs);
            check("model_overrun",    overrun,    m_ovr);
        end
    end

    // Receiver: samples each bit mid-way while busy; also tracks busy span and frame_sent pulses.
    logic [7:0] rx_q [$];
    logic [7:0] rx_byte = '0;
    int rx_cnt = 0, blen = 0, last_blen = 0, fs_count = 0;

    initial forever begin
        @(negedge clk);
        if (frame_sent) fs_count++;
        if (busy) begin
            if (rx_cnt % CPB == CPB / 2) begin
                int pos;
                pos = (rx_cnt / CPB) % 10;
                if (pos >= 1 && pos <= 8) rx_byte[pos - 1] = uart_tx;
                if (pos == 9) rx_q.push_back(rx_byte);
            end
            rx_cnt++;
            blen++;
        end else begin
            rx_cnt = 0;
            if (blen != 0) last_blen = blen;
            blen = 0;
        end
    end

    task automatic pulse_surf(input logic [31:0] v);
        @(negedge clk); surf_valid = 1'b1; surf_data = v;
        @(negedge clk); surf_valid = 1'b0;
    endtask

    task automatic pulse_plane(input logic [31:0] v);
        @(negedge clk); plane_valid = 1'b1; plane_data = v;
        @(negedge clk); plane_valid = 1'b0;
    endtask

    task automatic pulse_both(input logic [31:0] s, input logic [31:0] p);
        @(negedge clk); surf_valid = 1'b1; surf_data = s; plane_valid = 1'b1; plane_data = p;
        @(negedge clk); surf_valid = 1'b0; plane_valid = 1'b0;
    endtask

    task automatic wait_sent(input string name);
        int i;
        for (i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (frame_sent) break;
        end
        check(name, i < 2000, 1'b1);
    endtask

    task automatic wait_busy(input string name);
        int i;
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy) break;
        end
        check(name, i < 100, 1'b1);
    endtask

    task automatic check_frame(input string name, input int off, input logic [7:0] exp [11]);
        logic [7:0] got;
        check({name, "_count"}, rx_q.size() >= off + 11, 1'b1);
        for (int i = 0; i < 11; i++) begin
            got = (off + i < rx_q.size()) ? rx_q[off + i] : 8'hxx;
            check($sformatf("%s_byte%0d", name, i), got, exp[i]);
        end
    endtask

    initial begin
        int fs_before;
        repeat (3) @(negedge clk);
        reset  = 1'b0;
        cmp_en = 1'b1;
        check("reset_tx",      uart_tx,    1'b1);
        check("reset_busy",    busy,       1'b0);
        check("reset_sent",    frame_sent, 1'b0);
        check("reset_overrun", overrun,    1'b0);

        // Surf then plane three cycles later.
        fs_before = fs_count;
        pulse_surf(32'h11223344);
        repeat (2) @(negedge clk);
        pulse_plane(32'h55667788);
        wait_sent("t1_sent");
        @(negedge clk);
        check_frame("t1", 0, '{8'hA5, 8'h5A, 8'h11, 8'h22, 8'h33, 8'h44,
                               8'h55, 8'h66, 8'h77, 8'h88, 8'h88});
        check("t1_busy_len", last_blen, 440);
        check("t1_pulses",   fs_count,  fs_before + 1);

        // Both strobes together, then a new pair arriving mid-frame.
        rx_q.delete();
        pulse_both(32'hFFFF_FFFF, 32'h0000_0000);
        wait_busy("t2_busy");
        repeat (100) @(negedge clk);
        pulse_surf(32'h0000_0001);
        repeat (5) @(negedge clk);
        pulse_plane(32'h0000_0002);
        wait_sent("t2_sent_a");
        @(negedge clk);
        check("t2_b2b_busy", busy,    1'b1);
        check("t2_b2b_tx",   uart_tx, 1'b0);
        wait_sent("t2_sent_b");
        check_frame("t2a", 0, '{8'hA5, 8'h5A, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                                8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
        check_frame("t2b", 11, '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h01,
                                 8'h00, 8'h00, 8'h00, 8'h02, 8'h03});
        check("t2_overrun", overrun, 1'b0);

        // Surf strobe in the very cycle the frame starts stays pending for the next frame.
        repeat (5) @(negedge clk);
        rx_q.delete();
        pulse_surf(32'h0A0B_0C0D);
        @(negedge clk); plane_valid = 1'b1; plane_data = 32'h1020_3040;
        @(negedge clk); plane_valid = 1'b0; surf_valid = 1'b1; surf_data = 32'hCAFE_F00D;
        @(negedge clk); surf_valid = 1'b0;
        wait_sent("t4_sent_a");
        repeat (20) @(negedge clk);
        check("t4_waits_partner", busy, 1'b0);
        pulse_plane(32'h0000_BEEF);
        wait_sent("t4_sent_b");
        check_frame("t4a", 0, '{8'hA5, 8'h5A, 8'h0A, 8'h0B, 8'h0C, 8'h0D,
                                8'h10, 8'h20, 8'h30, 8'h40, 8'h40});
        check_frame("t4b", 11, '{8'hA5, 8'h5A, 8'hCA, 8'hFE, 8'hF0, 8'h0D,
                                 8'h00, 8'h00, 8'hBE, 8'hEF, 8'h98});
        check("t4_overrun", overrun, 1'b0);

        // Overwritten pending surf value: newest wins and overrun sticks.
        repeat (5) @(negedge clk);
        rx_q.delete();
        pulse_surf(32'hAAAA_0000);
        repeat (2) @(negedge clk);
        pulse_surf(32'hBBBB_0000);
        check("t3_overrun", overrun, 1'b1);
        pulse_plane(32'h1234_5678);
        wait_sent("t3_sent");
        check_frame("t3", 0, '{8'hA5, 8'h5A, 8'hBB, 8'hBB, 8'h00, 8'h00,
                               8'h12, 8'h34, 8'h56, 8'h78, 8'h08});
        check("t3_overrun_sticky", overrun, 1'b1);

        // Reset during byte 5 abandons the frame; a fresh pair then goes out intact.
        repeat (5) @(negedge clk);
        pulse_both(32'h0102_0304, 32'h0506_0708);
        wait_busy("t5_busy");
        repeat (210) @(negedge clk);
        fs_before = fs_count;
        reset = 1'b1;
        @(negedge clk);
        check("t5_reset_tx",   uart_tx, 1'b1);
        check("t5_reset_busy", busy,    1'b0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("t5_no_pulse", fs_count, fs_before);
        check("t5_overrun",  overrun,  1'b0);
        rx_q.delete();
        pulse_both(32'hDEAD_BEEF, 32'h00C0_FFEE);
        wait_sent("t5_sent");
        @(negedge clk);
        check_frame("t5", 0, '{8'hA5, 8'h5A, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
                               8'h00, 8'hC0, 8'hFF, 8'hEE, 8'hF3});
        check("t5_busy_len", last_blen, 440);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/result_uart_packetizer.md
# result_uart_packetizer

Downstream consumer of the measurement pipeline: captures the accumulated sphere-surface result (`compl_surf`) and the plane-surface result (`plane_data`, qualified by `plane_calc_rdy`), and ships each matched pair to the host as a fixed 11-byte UART frame (8N1). It sits in `top` beside `sph_surf_acc` and `plane_surf_calc` and replaces the debug `je` probing as the result path off-board.

## Interface
Parameters:
- `CLKS_PER_BIT`, 868, clk cycles per UART bit (100 MHz / 115200); legal range 2..65535.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `surf_data`  in  32  accumulated sphere surface (`compl_surf`).
- `surf_valid`  in  1  one-cycle strobe, `surf_data` valid.
- `plane_data`  in  32  plane surface result.
- `plane_valid`  in  1  one-cycle strobe (`plane_calc_rdy`), `plane_data` valid.
- `uart_tx`  out  1  serial output, idle high.
- `busy`  out  1  high while a frame is being shifted.
- `frame_sent`  out  1  one-cycle pulse when a frame's last stop bit completes.
- `overrun`  out  1  sticky: a pending, not-yet-sent value was overwritten.

## Operation
- Reset values: `uart_tx`=1, `busy`=0, `frame_sent`=0, `overrun`=0; pending flags, holding registers, counters cleared; FSM in IDLE.
- Capture: `surf_valid` loads `surf_hold` and sets `surf_pend`; `plane_valid` likewise for `plane_hold`/`plane_pend`. Both strobes in one cycle: both captured. Captures accepted in every state, including mid-frame.
- Overrun: strobe while the corresponding pend flag is already set -> value overwritten (newest wins), `overrun` set until reset.
- Frame start: in IDLE with `surf_pend && plane_pend` -> snapshot both holds into the 64-bit shift payload, clear both pend flags, go to START. A strobe in that same cycle sets its pend flag again (set wins over clear) and is not an overrun.
- Frame format, bytes in order: 0xA5, 0x5A, surf[31:24], surf[23:16], surf[15:8], surf[7:0], plane[31:24], plane[23:16], plane[15:8], plane[7:0], checksum = XOR of bytes 2..9.
- Byte encoding: start bit 0, 8 data bits LSB first, stop bit 1; no idle gap between bytes.
- FSM: IDLE -> START (1 bit) -> DATA (8 bits, bit counter 0..7) -> STOP (1 bit) -> START if byte index < 10 else IDLE. Byte index 0..10, reset to 0 at frame start.
- Checksum accumulated from snapshot bytes, not from live holds; later captures never corrupt the frame in flight.
- Reset mid-frame: `uart_tx` returns high the next cycle, frame abandoned, pend flags cleared; no `frame_sent`.

## Timing
- Frame-start condition sampled at edge k; `busy`=1 and `uart_tx`=0 (start bit of byte 0) from k+1.
- Each bit held exactly `CLKS_PER_BIT` cycles via a down-counter reloaded at every bit boundary.
- Frame length 110 bits = 110*`CLKS_PER_BIT` cycles; `busy` high for exactly that span.
- `frame_sent` high for the single cycle after the last stop-bit cycle; `busy` falls in that same cycle, `uart_tx` stays 1.
- Back-to-back: if both pend flags are set when the frame ends, next start bit begins the cycle after `frame_sent` (one idle-high cycle between frames).
- `overrun` asserts the cycle after the offending strobe.

## Test plan
- `CLKS_PER_BIT`=4; surf 0x11223344, then plane 0x55667788 three cycles later -> bytes A5 5A 11 22 33 44 55 66 77 88 with checksum 0x88; `busy` 440 cycles; one `frame_sent` pulse.
- Both strobes same cycle (surf 0xFFFFFFFF, plane 0x00000000) -> start bit next cycle; checksum 0x00; bit widths exactly 4 cycles each.
- Mid-frame new pair (0x01, 0x02) -> current frame unchanged; second frame starts one cycle after `frame_sent` carrying 00 00 00 01 00 00 00 02, checksum 0x03; `overrun`=0.
- Two `surf_valid` (0xAAAA0000, then 0xBBBB0000) before any plane -> `overrun`=1; frame carries 0xBBBB0000.
- Strobe coincident with frame-start cycle -> its pend flag stays set; next frame sends it after the new partner arrives.
- Assert `reset` during byte 5 -> `uart_tx`=1, `busy`=0 next cycle, no `frame_sent`; fresh pair afterwards yields a correct full frame.
